ahb_bram_bridge: RTL and testbench

- AHB-Lite slave bridging the Cortex-M0 system bus to the dual-address block RAM.
- Sits directly upstream of the RAM. Drives its write port (address, byte enables, data) and read address, and returns its 1-cycle-latency read data as HRDATA.
- Zero wait state. Converts AHB address/data phase pipelining into RAM timing.
- Forwards write data to cover the read-after-write hazard of the RAM's read-before-write behaviour.

---
 rtl/ahb_bram_bridge.sv | 120 ++++++++++++
 tb/tb_ahb_bram_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_bridge.sv
// AHB-Lite zero-wait-state slave in front of a dual-address block RAM.
// The RAM has a registered read port with 1-cycle latency and reads the old word
// when the same word is written on that edge. This bridge lines the AHB
// address and data phases up with the RAM ports. When a read directly follows a
// write to the same word, it forwards the written bytes to the read data.
module ahb_bram_bridge #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    input  logic [31:0]           BRAM_RDATA
);

    // Byte lanes touched by a transfer of the given size at the given byte offset.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    logic                  acc_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [3:0]            mask_s;

    logic                  wr_pend_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [3:0]            wr_mask_r;
    logic                  fwd_hit_r;
    logic [3:0]            fwd_mask_r;
    logic [31:0]           fwd_data_r;

    // Bits that do not take part in decoding: upper address bits alias, and
    // SEQ is treated the same as NONSEQ.
    logic unused_s;
    assign unused_s = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign acc_s    = HSEL & HTRANS[1] & HREADY;
    assign wr_acc_s = acc_s & HWRITE;
    assign rd_acc_s = acc_s & ~HWRITE;
    assign addr_s   = HADDR[ADDR_WIDTH+1:2];
    assign mask_s   = byte_mask(HSIZE, HADDR[1:0]);

    // The read address goes to the RAM straight from the bus every cycle.
    // The RAM's own output register aligns the read data with the data phase.
    assign BRAM_RDADDR = addr_s;
    assign BRAM_WRADDR = wr_addr_r;
    assign BRAM_WDATA  = HWDATA;
    assign BRAM_WE     = wr_pend_r ? wr_mask_r : 4'b0000;
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;

    // Capture the write address phase so the RAM write lands in the data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= '0;
            wr_mask_r <= 4'b0000;
        end else if (wr_acc_s) begin
            wr_pend_r <= 1'b1;
            wr_addr_r <= addr_s;
            wr_mask_r <= mask_s;
        end else begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_mask_r <= wr_mask_r;
        end
    end

    // Remember the data being written when a read of the same word follows.
    // The RAM returns the old word on that edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fwd_hit_r  <= 1'b0;
            fwd_mask_r <= 4'b0000;
            fwd_data_r <= 32'h0000_0000;
        end else if (rd_acc_s && wr_pend_r && (addr_s == wr_addr_r)) begin
            fwd_hit_r  <= 1'b1;
            fwd_mask_r <= wr_mask_r;
            fwd_data_r <= HWDATA;
        end else begin
            fwd_hit_r  <= 1'b0;
            fwd_mask_r <= fwd_mask_r;
            fwd_data_r <= fwd_data_r;
        end
    end

    // Merge the forwarded bytes over the RAM read data, lane by lane.
    always_comb begin
        HRDATA = BRAM_RDATA;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit_r && fwd_mask_r[i]) begin
                HRDATA[8*i +: 8] = fwd_data_r[8*i +: 8];
            end else begin
                HRDATA[8*i +: 8] = BRAM_RDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Scoreboard bench for ahb_bram_bridge with a behavioural read-before-write RAM.
module tb_ahb_bram_bridge;

    localparam int AW = 14;

    logic          HCLK;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] BRAM_RDADDR;
    logic [AW-1:0] BRAM_WRADDR;
    logic [31:0]   BRAM_WDATA;
    logic [3:0]    BRAM_WE;
    logic [31:0]   BRAM_RDATA;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];

    ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BRAM_RDADDR(BRAM_RDADDR), .BRAM_WRADDR(BRAM_WRADDR),
        .BRAM_WDATA(BRAM_WDATA), .BRAM_WE(BRAM_WE), .BRAM_RDATA(BRAM_RDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Block RAM model: registered read, old data returned on a same-word write.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        BRAM_RDATA <= mem[BRAM_RDADDR];
        for (int i = 0; i < 4; i++)
            if (BRAM_WE[i]) mem[BRAM_WRADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks accepted transfers and checks their data phases.
    logic m_wr = 1'b0;
    logic m_rd = 1'b0;
    initial begin
        wr_exp_t e;
        forever begin
            @(posedge HCLK);
            if (HRESET) begin
                m_wr = 1'b0;
                m_rd = 1'b0;
            end else begin
                m_wr = HSEL & HTRANS[1] & HREADY & HWRITE;
                m_rd = HSEL & HTRANS[1] & HREADY & ~HWRITE;
            end
            @(negedge HCLK);
            chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
            chk("hresp", {31'd0, HRESP}, 32'd0);
            if (HRESET) begin
                chk("we_in_reset", {28'd0, BRAM_WE}, 32'd0);
            end else if (m_wr) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected_we", {28'd0, BRAM_WE}, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    chk("bram_we", {28'd0, BRAM_WE}, {28'd0, e.we});
                    chk("bram_wraddr", {{(32-AW){1'b0}}, BRAM_WRADDR}, {{(32-AW){1'b0}}, e.addr});
                    chk("bram_wdata", BRAM_WDATA, e.data);
                end
            end else begin
                chk("we_idle", {28'd0, BRAM_WE}, 32'd0);
            end
            if (!HRESET && m_rd) begin
                if (rd_q.size() == 0) chk("rd_no_expect", 32'd1, 32'd0);
                else chk("hrdata", HRDATA, rd_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr, input logic rdy,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        HSEL = sel; HTRANS = trans; HWRITE = wr; HREADY = rdy;
        HADDR = addr; HSIZE = size; HWDATA = wdata;
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr_ph(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        cyc(1'b1, 2'b10, 1'b1, 1'b1, addr, size, wdata);
    endtask

    task automatic rd_ph(input logic [31:0] addr, input logic [31:0] wdata);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, addr, 3'd2, wdata);
    endtask

    task automatic idle(input logic [31:0] wdata);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0000, 3'd0, wdata);
    endtask

    task automatic exp_wr(input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] data);
        wr_exp_t e;
        e.we = we; e.addr = addr; e.data = data;
        wr_q.push_back(e);
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
        HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_we", {28'd0, BRAM_WE}, 32'd0);
        HRESET = 1'b0;

        // Word write then read.
        wr_ph(32'h40, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h10, 32'hDEADBEEF);
        idle(32'hDEADBEEF);
        rd_q.push_back(32'hDEADBEEF);
        rd_ph(32'h40, 32'h0);
        idle(32'h0);

        // Byte and halfword lanes over 0x11223344.
        wr_ph(32'h40, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h10, 32'h11223344);
        wr_ph(32'h41, 3'd0, 32'h11223344);
        exp_wr(4'b0010, 14'h10, 32'h0000AA00);
        wr_ph(32'h42, 3'd1, 32'h0000AA00);
        exp_wr(4'b1100, 14'h10, 32'h55660000);
        idle(32'h55660000);
        rd_q.push_back(32'h5566AA44);
        rd_ph(32'h40, 32'h0);
        idle(32'h0);

        // RAW hazard: word, then byte, then a non-matching address.
        wr_ph(32'h80, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h20, 32'h00000000);
        idle(32'h00000000);
        wr_ph(32'h80, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h20, 32'h12345678);
        rd_q.push_back(32'h12345678);
        rd_ph(32'h80, 32'h12345678);
        idle(32'h0);
        wr_ph(32'h80, 3'd0, 32'h0);
        exp_wr(4'b0001, 14'h20, 32'h000000FF);
        rd_q.push_back(32'h123456FF);
        rd_ph(32'h80, 32'h000000FF);
        idle(32'h0);
        wr_ph(32'h84, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h21, 32'hA5A5A5A5);
        rd_q.push_back(32'h123456FF);
        rd_ph(32'h80, 32'hA5A5A5A5);
        idle(32'h0);

        // No-access cycles: IDLE, BUSY, HSEL low, HREADY low.
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 32'h80, 3'd2, 32'h0);
        cyc(1'b1, 2'b01, 1'b1, 1'b1, 32'h80, 3'd2, 32'hBAD0BAD0);
        cyc(1'b0, 2'b10, 1'b1, 1'b1, 32'h80, 3'd2, 32'hBAD0BAD0);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 32'h80, 3'd2, 32'hBAD0BAD0);
        idle(32'hBAD0BAD0);
        rd_q.push_back(32'h123456FF);
        rd_ph(32'h80, 32'h0);
        idle(32'h0);

        // Reset during a write data phase drops the write.
        wr_ph(32'h100, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h40, 32'hCAFEF00D);
        idle(32'hCAFEF00D);
        wr_ph(32'h100, 3'd2, 32'h0);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55555555;
        #1;
        chk("pend_we_before_reset", {28'd0, BRAM_WE}, 32'h0000000F);
        HRESET = 1'b1;
        #1;
        chk("async_reset_we", {28'd0, BRAM_WE}, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(32'h0);
        rd_q.push_back(32'hCAFEF00D);
        rd_ph(32'h100, 32'h0);
        idle(32'h0);

        // Back-to-back writes, then reads including an aliased address.
        wr_ph(32'h0, 3'd2, 32'h0);
        exp_wr(4'b1111, 14'h0, 32'h11111111);
        wr_ph(32'h4, 3'd2, 32'h11111111);
        exp_wr(4'b1111, 14'h1, 32'h22222222);
        wr_ph(32'h8, 3'd2, 32'h22222222);
        exp_wr(4'b1111, 14'h2, 32'h33333333);
        rd_q.push_back(32'h11111111);
        rd_ph(32'h0, 32'h33333333);
        rd_q.push_back(32'h22222222);
        rd_ph(32'h4, 32'h0);
        rd_q.push_back(32'h33333333);
        rd_ph(32'h8, 32'h0);
        rd_q.push_back(32'h22222222);
        rd_ph(32'h0001_0004, 32'h0);
        repeat (3) idle(32'h0);

        chk("wr_q_drained", wr_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
